// File: rtl/gate_scheduler.sv
// rtl/gate_scheduler.sv - walks the gate list once per sequential circuit cycle and offers each gate to the garbling engine
module gate_scheduler #(
    parameter int S    = 20,
    parameter int CC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CC_W-1:0]   num_cc,
    output logic              nl_start,
    input  logic              nl_done,
    input  logic [S-1:0]      gate_size,
    input  logic [3:0]        g_logic,
    output logic [S-1:0]      rd_addr,
    output logic              g_valid,
    input  logic              g_ready,
    output logic              g_last,
    output logic [CC_W-1:0]   cc_idx,
    output logic              cc_done,
    output logic [S+CC_W-1:0] nonxor_cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, CC_END, FIN} state_t;

    localparam logic [S-1:0]      S_ONE  = S'(1);
    localparam logic [CC_W-1:0]   CC_ONE = CC_W'(1);
    localparam logic [S+CC_W-1:0] NX_ONE = (S + CC_W)'(1);

    state_t              state_q, state_d;
    logic [CC_W-1:0]     num_cc_q, num_cc_d;
    logic [S-1:0]        gate_size_q, gate_size_d;
    logic [S-1:0]        rd_addr_q, rd_addr_d;
    logic [CC_W-1:0]     cc_idx_q, cc_idx_d;
    logic [S+CC_W-1:0]   nonxor_q, nonxor_d;
    logic                nl_start_q, nl_start_d;
    logic                last_gate;
    logic                non_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_cc_q    <= '0;
            gate_size_q <= '0;
            rd_addr_q   <= '0;
            cc_idx_q    <= '0;
            nonxor_q    <= '0;
            nl_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_cc_q    <= num_cc_d;
            gate_size_q <= gate_size_d;
            rd_addr_q   <= rd_addr_d;
            cc_idx_q    <= cc_idx_d;
            nonxor_q    <= nonxor_d;
            nl_start_q  <= nl_start_d;
        end
    end

    assign last_gate = (rd_addr_q == gate_size_q - S_ONE);
    // XOR and XNOR are free under free-XOR garbling; everything else costs a table
    assign non_free  = (g_logic != 4'b0110) && (g_logic != 4'b1001);

    always_comb begin
        state_d     = state_q;
        num_cc_d    = num_cc_q;
        gate_size_d = gate_size_q;
        rd_addr_d   = rd_addr_q;
        cc_idx_d    = cc_idx_q;
        nonxor_d    = nonxor_q;
        nl_start_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_cc_d   = num_cc;
                    nonxor_d   = '0;
                    cc_idx_d   = '0;
                    rd_addr_d  = '0;
                    nl_start_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (nl_done) begin
                    gate_size_d = gate_size;
                    rd_addr_d   = '0;
                    if (num_cc_q == '0 || gate_size == '0) state_d = FIN;
                    else                                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (g_ready) begin
                    if (non_free && nonxor_q != '1) nonxor_d = nonxor_q + NX_ONE;
                    if (last_gate) state_d   = CC_END;
                    else           rd_addr_d = rd_addr_q + S_ONE;
                end
            end
            CC_END: begin
                if (cc_idx_q == num_cc_q - CC_ONE) begin
                    state_d = FIN;
                end else begin
                    cc_idx_d  = cc_idx_q + CC_ONE;
                    rd_addr_d = '0;
                    state_d   = ISSUE;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign nl_start   = nl_start_q;
    assign rd_addr    = rd_addr_q;
    assign g_valid    = (state_q == ISSUE);
    assign g_last     = (state_q == ISSUE) && last_gate;
    assign cc_idx     = cc_idx_q;
    assign cc_done    = (state_q == CC_END);
    assign nonxor_cnt = nonxor_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);

endmodule

// File: doc/gate_scheduler.md
GATE_SCHEDULER -- requirements
Module: gate_scheduler

Interface
REQ-001 Parameter S, default 20, SHALL set the address/size width and match the netlist reader.
REQ-002 Parameter CC_W, default 16, SHALL set the width of the sequential-cycle counter.
REQ-003 clk  input  1  single clock; all sequential logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  run request, sampled in IDLE only.
REQ-006 num_cc  input  CC_W  number of sequential circuit cycles to garble, sampled with start.
REQ-007 nl_start  output  1  one-cycle pulse to the netlist reader to load its header.
REQ-008 nl_done  input  1  header valid from the netlist reader; gate_size is valid in the same cycle.
REQ-009 gate_size  input  S  gates per circuit cycle.
REQ-010 g_logic  input  4  gate truth table of the gate at rd_addr, combinational from rd_addr.
REQ-011 rd_addr  output  S  gate index presented to the netlist reader.
REQ-012 g_valid  output  1  gate at rd_addr is offered to the garbling engine.
REQ-013 g_ready  input  1  garbling engine accepts the offered gate.
REQ-014 g_last  output  1  offered gate is the last gate of the current circuit cycle.
REQ-015 cc_idx  output  CC_W  index of the current circuit cycle.
REQ-016 cc_done  output  1  one-cycle pulse at the end of each circuit cycle (DFF label update).
REQ-017 nonxor_cnt  output  S+CC_W  count of accepted non-free gates in the current run.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse at run completion.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, ISSUE, CC_END, FIN; all outputs registered or decoded from registered state only.
REQ-021 IDLE: start=1 SHALL capture num_cc, clear nonxor_cnt and cc_idx, and enter LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-022 LOAD: nl_start SHALL be 1 only in the first LOAD cycle; the FSM waits in LOAD until nl_done=1, then captures gate_size.
REQ-023 On nl_done: num_cc=0 or gate_size=0 SHALL go to FIN with no gate issued and no cc_done; otherwise go to ISSUE with rd_addr=0.
REQ-024 ISSUE: g_valid SHALL be 1; rd_addr SHALL hold stable while g_valid=1 and g_ready=0.
REQ-025 A transfer SHALL occur on a cycle with g_valid=1 and g_ready=1; one gate per cycle maximum (back-to-back transfers with g_ready held high).
REQ-026 g_last SHALL equal g_valid AND (rd_addr == gate_size-1).
REQ-027 A transfer without g_last SHALL increment rd_addr by 1; a transfer with g_last SHALL enter CC_END and leave rd_addr unchanged.
REQ-028 Each transfer with g_logic not equal to 4'b0110 (XOR) or 4'b1001 (XNOR) SHALL increment nonxor_cnt by 1; nonxor_cnt saturates at all-ones.
REQ-029 CC_END: cc_done SHALL be 1 for exactly this one cycle; g_valid SHALL be 0.
REQ-030 From CC_END: cc_idx == num_cc-1 SHALL go to FIN; otherwise cc_idx increments, rd_addr returns to 0, and the FSM goes to ISSUE.
REQ-031 FIN: done SHALL be 1 for exactly one cycle, then IDLE; nonxor_cnt and cc_idx hold until the next start.
REQ-032 Minimum latency, start to first g_valid: start cycle, 1 LOAD cycle if nl_done arrives in the first LOAD cycle, then g_valid next cycle.
REQ-033 Total transfers per run SHALL equal gate_size x num_cc exactly.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE and clear rd_addr, cc_idx, nonxor_cnt, and the captured num_cc and gate_size.
REQ-035 While rst_n=0, all outputs (nl_start, g_valid, g_last, cc_done, busy, done) SHALL be 0, including when reset asserts mid-ISSUE with a gate pending.
REQ-036 After rst_n deasserts, the first run SHALL behave identically to a run from power-up.

Verification
REQ-037 Test 1: gate_size=4, num_cc=1, g_ready=1 -> rd_addr 0,1,2,3 on consecutive cycles, g_last at 3, one cc_done, then done.
REQ-038 Test 2: gate_size=3, num_cc=2, g_ready low 2 cycles on gate 1 -> rd_addr held at 1; 6 transfers total; cc_done twice; cc_idx 0 then 1.
REQ-039 Test 3: g_logic sequence XOR, AND, XNOR, OR over gate_size=4, num_cc=3 -> nonxor_cnt=6 at done.
REQ-040 Test 4: num_cc=0 or gate_size=0 -> nl_start pulse, no g_valid, no cc_done, done one cycle after nl_done.
REQ-041 Test 5: rst_n low during ISSUE at rd_addr=2 -> g_valid and busy drop immediately; new start restarts at rd_addr=0, nonxor_cnt=0.
REQ-042 Test 6: start pulsed while busy -> no effect; transfer count and done timing unchanged.
